// File: rtl/fifo_pkg.sv
// ============================================================================
// Module  : fifo_pkg
// Brief   : Shared width helpers and status struct for the fifo_count slice.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package fifo_pkg;

    // Pointer width never collapses to zero bits, even for tiny depths.
    function automatic int ptr_w(input int depth);
        int w;
        w = $clog2(depth);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
    } fifo_status_t;

endpackage

`default_nettype wire

// File: rtl/fifo_count_if.sv
// ============================================================================
// Module  : fifo_count_if
// Brief   : Enqueue/dequeue valid-ready link bundle for fifo_count.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface fifo_count_if #(
    parameter int DATA_W = 32
) ();
    logic [DATA_W-1:0] enq_data;
    logic              enq_valid;
    logic              enq_ready;
    logic [DATA_W-1:0] deq_data;
    logic              deq_valid;
    logic              deq_ready;

    // master: producer and consumer side; slave: the FIFO itself
    modport master (
        output enq_data, enq_valid, deq_ready,
        input  enq_ready, deq_data, deq_valid
    );

    modport slave (
        input  enq_data, enq_valid, deq_ready,
        output enq_ready, deq_data, deq_valid
    );
endinterface

`default_nettype wire

// File: rtl/fifo_wrap_ptr.sv
// ============================================================================
// Module  : fifo_wrap_ptr
// Brief   : Modulo-DEPTH binary pointer with synchronous clear.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module fifo_wrap_ptr
    import fifo_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = ptr_w(DEPTH)
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             clr,
    input  wire logic             inc,
    output logic      [PTR_W-1:0] ptr
);

    localparam logic [PTR_W-1:0] C_LAST = PTR_W'(DEPTH - 1);

    logic [PTR_W-1:0] r_ptr;

    // Explicit wrap keeps non-power-of-two depths inside the storage range.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (clr) begin
            r_ptr <= '0;
        end else if (inc) begin
            r_ptr <= (r_ptr == C_LAST) ? '0 : r_ptr + PTR_W'(1);
        end
    end

    assign ptr = r_ptr;

endmodule

`default_nettype wire

// File: rtl/fifo_count.sv
// ============================================================================
// Module  : fifo_count
// Brief   : Any-depth synchronous FIFO with occupancy count and threshold
//           flags; define FIFO_BYPASS_EN for a zero-latency empty bypass.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module fifo_count
    import fifo_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 4,
    parameter int AF_THRESH = DEPTH - 1,
    parameter int AE_THRESH = 1,
    localparam int CNT_W    = cnt_w(DEPTH)
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             flush,
    fifo_count_if.slave           link,
    output logic      [CNT_W-1:0] count,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty
);

    localparam int               PTR_W = ptr_w(DEPTH);
    localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] C_AF    = CNT_W'(AF_THRESH);
    localparam logic [CNT_W-1:0] C_AE    = CNT_W'(AE_THRESH);

    generate
        if (DEPTH < 2) begin : g_bad_depth
            $fatal(1, "fifo_count: DEPTH must be at least 2");
        end
        if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
            $fatal(1, "fifo_count: AF_THRESH must be within 1..DEPTH");
        end
        if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
            $fatal(1, "fifo_count: AE_THRESH must be within 0..DEPTH-1");
        end
    endgenerate

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [CNT_W-1:0]  r_count;
    logic [PTR_W-1:0]  w_wr_ptr;
    logic [PTR_W-1:0]  w_rd_ptr;
    fifo_status_t      w_status;
    logic              w_bypass;
    logic              w_enq_fire;
    logic              w_deq_fire;
    logic              w_write;
    logic              w_pop;

    // Flags decode from the registered count only.
    assign w_status.full         = (r_count == C_DEPTH);
    assign w_status.empty        = (r_count == '0);
    assign w_status.almost_full  = (r_count >= C_AF);
    assign w_status.almost_empty = (r_count <= C_AE);

`ifdef FIFO_BYPASS_EN
    assign w_bypass = w_status.empty & link.enq_valid & ~flush;
`else
    assign w_bypass = 1'b0;
`endif

    assign link.enq_ready = ~w_status.full | link.deq_ready;
    assign link.deq_valid = ~w_status.empty | w_bypass;

    always_comb begin
        link.deq_data = '0;
        if (!w_status.empty) begin
            link.deq_data = r_mem[w_rd_ptr];
        end else if (w_bypass) begin
            link.deq_data = link.enq_data;
        end
    end

    assign w_enq_fire = link.enq_valid & link.enq_ready;
    assign w_deq_fire = link.deq_valid & link.deq_ready;
    // A bypassed word that is taken immediately never touches storage.
    assign w_pop      = w_deq_fire & ~w_status.empty;
    assign w_write    = w_enq_fire & ~(w_bypass & link.deq_ready) & ~flush;

    always_ff @(posedge clk) begin
        if (w_write) begin
            r_mem[w_wr_ptr] <= link.enq_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (flush) begin
            r_count <= '0;
        end else if (w_write && !w_pop) begin
            r_count <= r_count + CNT_W'(1);
        end else if (!w_write && w_pop) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    fifo_wrap_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush),
        .inc   (w_write),
        .ptr   (w_wr_ptr)
    );

    fifo_wrap_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush),
        .inc   (w_pop),
        .ptr   (w_rd_ptr)
    );

    assign count        = r_count;
    assign full         = w_status.full;
    assign empty        = w_status.empty;
    assign almost_full  = w_status.almost_full;
    assign almost_empty = w_status.almost_empty;

endmodule

`default_nettype wire

// File: tb/tb_fifo_count.sv
// ============================================================================
// Module  : tb_fifo_count
// Brief   : Queue-model scoreboard bench for fifo_count (DEPTH=5, AF=4, AE=1).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fifo_count;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 5;
    localparam int AF     = 4;
    localparam int AE     = 1;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush = 1'b0;
    logic [CNT_W-1:0] count;
    logic             full, empty, almost_full, almost_empty;

    fifo_count_if #(.DATA_W(DATA_W)) link ();

    fifo_count #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .AF_THRESH (AF),
        .AE_THRESH (AE)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .link         (link),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] model_q[$];
    logic [31:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus: drive, check visible state against the queue model,
    // queue the word expected to leave, then advance the model.
    task automatic cycle(input logic ev, input logic [31:0] ed, input logic dr, input logic fl);
        int          sz;
        logic        byp, exp_valid, exp_ready, efire, dfire;
        logic [31:0] head;
        @(negedge clk);
        link.enq_valid = ev;
        link.enq_data  = ed;
        link.deq_ready = dr;
        flush          = fl;
        #1;
        sz  = model_q.size();
        byp = 1'b0;
`ifdef FIFO_BYPASS_EN
        byp = (sz == 0) && ev && !fl;
`endif
        exp_valid = (sz > 0) || byp;
        exp_ready = (sz < DEPTH) || dr;
        head      = (sz > 0) ? model_q[0] : (byp ? ed : 32'h0);
        chk("count",        32'(count),          32'(sz));
        chk("full",         32'(full),           32'(sz == DEPTH));
        chk("empty",        32'(empty),          32'(sz == 0));
        chk("almost_full",  32'(almost_full),    32'(sz >= AF));
        chk("almost_empty", 32'(almost_empty),   32'(sz <= AE));
        chk("enq_ready",    32'(link.enq_ready), 32'(exp_ready));
        chk("deq_valid",    32'(link.deq_valid), 32'(exp_valid));
        chk("deq_data",     link.deq_data,       head);
        efire = ev && exp_ready;
        dfire = exp_valid && dr;
        if (dfire) exp_q.push_back(head);
        if (fl) begin
            model_q.delete();
        end else begin
            if (dfire && sz > 0) void'(model_q.pop_front());
            if (efire && !(byp && dr)) model_q.push_back(ed);
        end
    endtask

    task automatic mid_reset();
        @(negedge clk);
        link.enq_valid = 1'b0;
        link.deq_ready = 1'b0;
        flush          = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_count",     32'(count),          32'h0);
        chk("rst_empty",     32'(empty),          32'h1);
        chk("rst_deq_valid", 32'(link.deq_valid), 32'h0);
        chk("rst_enq_ready", 32'(link.enq_ready), 32'h1);
        chk("rst_deq_data",  link.deq_data,       32'h0);
        model_q.delete();
        exp_q.delete();
        @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Monitor: every accepted dequeue must match the oldest scoreboard entry.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && link.deq_valid && link.deq_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_deq: got 0x%0h, expected no transfer at %0t",
                             link.deq_data, $time);
                end else begin
                    chk("deq_order", link.deq_data, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        link.enq_valid = 1'b0;
        link.enq_data  = '0;
        link.deq_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        cycle(1'b0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b1, 32'hA0 + 32'(i), 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 1'b0);
        cycle(1'b1, 32'hB5, 1'b1, 1'b0);
        repeat (6) cycle(1'b0, 32'h0, 1'b1, 1'b0);

        for (int i = 0; i < 7; i++) cycle(1'b1, 32'hD0 + 32'(i), (i >= 2), 1'b0);
        repeat (6) cycle(1'b0, 32'h0, 1'b1, 1'b0);

        for (int i = 0; i < 3; i++) cycle(1'b1, 32'hE0 + 32'(i), 1'b0, 1'b0);
        cycle(1'b1, 32'hEE, 1'b1, 1'b1);
        cycle(1'b0, 32'h0, 1'b0, 1'b0);
        cycle(1'b1, 32'hF0, 1'b0, 1'b0);
        repeat (2) cycle(1'b0, 32'h0, 1'b1, 1'b0);

        cycle(1'b1, 32'hC3, 1'b1, 1'b0);
        repeat (2) cycle(1'b0, 32'h0, 1'b1, 1'b0);

        cycle(1'b1, 32'h11, 1'b0, 1'b0);
        cycle(1'b1, 32'h22, 1'b0, 1'b0);
        mid_reset();
        repeat (2) cycle(1'b0, 32'h0, 1'b1, 1'b0);

        for (int i = 0; i < 1500; i++) begin
            bit hi;
            hi = ((i / 250) % 2) == 1;
            cycle(($urandom_range(99) < (hi ? 85 : 40)),
                  $urandom,
                  ($urandom_range(99) < (hi ? 30 : 80)),
                  ($urandom_range(99) < 2));
        end

        repeat (8) cycle(1'b0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        #3;
        chk("leftover_expected", 32'(exp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fifo_count.md
# fifo_count

Parametrised synchronous FIFO: the next-generation replacement for the single- and n-entry buffers used on internal valid/ready links. Adds any-integer depth with binary wrap pointers, an occupancy count, almost-full/almost-empty thresholds, and enqueue-while-full when a dequeue happens in the same cycle. An optional zero-latency bypass path is selected at compile time. Used anywhere two pipeline stages need elastic decoupling, or where back-pressure must be anticipated.

## Interface
- DATA_W, 32, payload width in bits (≥1)
- DEPTH, 4, number of storage entries (≥2, any integer; does not have to be a power of two)
- AF_THRESH, DEPTH-1, almost_full asserts when count ≥ AF_THRESH (1..DEPTH)
- AE_THRESH, 1, almost_empty asserts when count ≤ AE_THRESH (0..DEPTH-1)
- clk  input  1  clock; all state updates on its rising edge
- rst_n  input  1  reset, asynchronous, active-low
- enq_data  input  DATA_W  write payload
- enq_valid  input  1  producer offers enq_data
- enq_ready  output  1  FIFO accepts this cycle
- deq_data  output  DATA_W  head-of-queue payload
- deq_valid  output  1  head entry is valid
- deq_ready  input  1  consumer takes the head entry
- flush  input  1  synchronous clear; takes priority over enq and deq
- count  output  CNT_W  occupancy, CNT_W = $clog2(DEPTH+1)
- full, empty, almost_full, almost_empty  output  1 each  status flags

## Operation
- Transfer rules: enq fires when enq_valid & enq_ready. deq fires when deq_valid & deq_ready.
- Pointers: wr_ptr and rd_ptr are binary, width $clog2(DEPTH). Each advances by 1 on its own fire. At DEPTH-1 it wraps explicitly to 0.
- count update: +1 on enq only, -1 on deq only, unchanged when both or neither fire.
- Flag definitions:
  - full = (count == DEPTH)
  - empty = (count == 0)
  - almost_full = (count ≥ AF_THRESH)
  - almost_empty = (count ≤ AE_THRESH)
- enq_ready = !full | deq_ready. When full and a deq fires, the enq in the same cycle is accepted into the slot just freed. Order is preserved and count stays at DEPTH.
- deq_valid = !empty.
- deq_data = storage[rd_ptr] when deq_valid, else 0.
- Storage is written only on enq fire and is not reset.
- Empty with enq_valid=1 and deq_ready=1 (bypass off): the write is accepted, no deq fires, and count becomes 1.
- flush=1: at the next edge, wr_ptr, rd_ptr and count all go to 0. Any enq or deq in that cycle is discarded. Handshake outputs still follow the rules above during the flush cycle.
- Reset values: pointers and count = 0, so the outputs are count=0, empty=1, almost_empty=1, full=0, almost_full=0, deq_valid=0, enq_ready=1, deq_data=0.
- Reset asserted mid-operation: the same values take effect immediately (asynchronously) and all queued content is lost.
- Illegal parameters cause an elaboration-time $fatal: DEPTH<2, AF_THRESH∉[1,DEPTH], or AE_THRESH∉[0,DEPTH-1].

## Timing
- Latency: enq fire at edge N produces deq_valid=1 after edge N (visible in cycle N+1). The bypass configuration is described below.
- Throughput: one enq and one deq per cycle sustained, including while full.
- count and all status flags decode from registered state only; none has a combinational path from any input.
- Combinational paths:
  - deq_ready → enq_ready, active only when full.
  - With bypass: enq_valid/enq_data → deq_valid/deq_data.

## Configuration
- FIFO_BYPASS_EN defined:
  - Applies when empty, enq_valid=1 and flush=0.
  - deq_valid=1 and deq_data=enq_data in the same cycle (zero latency).
  - If deq_ready=1, both fires occur, nothing is written, and count stays 0.
  - If deq_ready=0, the data is written normally and count becomes 1.
- FIFO_BYPASS_EN undefined:
  - No comb path from the enq side to the deq side.
  - Minimum latency is 1 cycle.

## Structure
- fifo_pkg holds:
  - function ptr_w(depth) returning max(1, $clog2(depth));
  - function cnt_w(depth) returning $clog2(depth+1);
  - a shared status struct typedef fifo_status_t {full, empty, almost_full, almost_empty}.
- Sub-module fifo_wrap_ptr (parameter DEPTH):
  - Ports: clk, rst_n, clr, inc, ptr.
  - Modulo-DEPTH counter with synchronous clear, instantiated once for wr_ptr and once for rd_ptr.
- Storage is a flat register array in fifo_count. Occupancy and flag logic also live in fifo_count.

## Test plan
1. Reset: release rst_n with DEPTH=5 → count=0, empty=1, almost_empty=1, enq_ready=1, deq_valid=0, deq_data=0.
2. Fill and wrap, DEPTH=5:
   - Enqueue 0xA0..0xA4 → full=1, count=5, enq_ready=0.
   - Drain all, then enqueue 7 more, drain 7 → output order is exact. rd_ptr wraps 4→0 with no duplicates.
3. Full with simultaneous ops: at count=5, enq 0xB5 and deq together → 0xA0 dequeued, count stays 5, 0xB5 emerges fifth.
4. Thresholds, AF_THRESH=4, AE_THRESH=1: step count 0→5→0 → almost_full high exactly at counts 4–5, almost_empty high exactly at counts 0–1.
5. Flush at count=3 with enq_valid=1 and deq_ready=1 → next cycle count=0, empty=1, and neither the offered enq data nor the head data appears afterwards.
6. Bypass, FIFO_BYPASS_EN defined: empty, enq 0xC3 with deq_ready=1 → deq_data=0xC3 in the same cycle and count stays 0. Repeat with FIFO_BYPASS_EN undefined → deq_valid rises one cycle later.
